// File: rtl/pll_seq_pkg.sv
// Shared types and width helpers for the PLL enable-clock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RST_PLL,
        WAIT_LOCK,
        STAGE,
        RUN,
        FAIL
    } pll_state_t;

    localparam int LOSS_CNT_W = 16;

    // Width of a counter that runs from 0 to n-1.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Two-flop synchroniser for the raw PLL lock plus a consecutive-high filter.
module pll_lock_filter
    import pll_seq_pkg::*;
#(
    parameter int LOCK_FILT_CYCLES = 64
) (
    input  logic clkin,
    input  logic reset,
    input  logic pll_lock,
    input  logic clr,
    output logic lock_ok
);

    localparam int FW = cnt_w(LOCK_FILT_CYCLES);
    localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILT_CYCLES - 1);

    logic          lock_meta;
    logic          lock_s;
    logic [FW-1:0] filt_cnt;

    // NOTE: pll_lock is asynchronous to clkin; it is only ever used after the
    // second flop so that metastability cannot reach the FSM.
    always_ff @(posedge clkin) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            filt_cnt  <= '0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
            if (clr || !lock_s)
                filt_cnt <= '0;
            else if (filt_cnt != FILT_LAST)
                filt_cnt <= filt_cnt + FW'(1);
        end
    end

    // Counter holds the number of earlier consecutive high cycles, so lock_ok
    // drops in the very cycle a low sample appears.
    assign lock_ok = lock_s && (filt_cnt == FILT_LAST);

endmodule

// File: rtl/pll_enclk_sequencer.sv
// PLL power-up / lock-supervision sequencer with staggered ENCLK release.
// Optional loss-of-lock counter port enabled by defining PLL_SEQ_LOSS_CNT_EN.
module pll_enclk_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_CLK             = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_FILT_CYCLES    = 64,
    parameter int STAGE_GAP_CYCLES    = 8,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                               clkin,
    input  logic                               reset,
    input  logic                               pll_lock,
    input  logic [NUM_CLK-1:0]                 en_req,
    input  logic                               restart,
    output logic                               pll_reset,
    output logic [NUM_CLK-1:0]                 enclk,
    output logic                               ready,
    output logic                               fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
`ifdef PLL_SEQ_LOSS_CNT_EN
    ,
    output logic [LOSS_CNT_W-1:0]              loss_cnt
`endif
);

    localparam int CW = cnt_w(max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, STAGE_GAP_CYCLES));
    localparam int IW = cnt_w(NUM_CLK);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(STAGE_GAP_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_CLK - 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

    pll_state_t          state, state_nxt;
    logic [CW-1:0]       cyc_cnt;
    logic [IW-1:0]       stage_idx;
    logic [RW-1:0]       retry_nxt;
    logic                lock_ok, filt_clr, release_bit;
    logic                pll_reset_nxt, ready_nxt, fail_nxt;
    logic [NUM_CLK-1:0]  enclk_nxt;

    assign filt_clr    = (state == RST_PLL) && (cyc_cnt == RST_LAST);
    assign release_bit = (state == STAGE) && (cyc_cnt == GAP_LAST);

    pll_lock_filter #(
        .LOCK_FILT_CYCLES (LOCK_FILT_CYCLES)
    ) u_lock_filter (
        .clkin    (clkin),
        .reset    (reset),
        .pll_lock (pll_lock),
        .clr      (filt_clr),
        .lock_ok  (lock_ok)
    );

    // NOTE: every always_ff uses non-blocking assignments only, and reset is
    // sampled on the clock edge (synchronous), never in the sensitivity list.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state     <= RST_PLL;
            cyc_cnt   <= '0;
            stage_idx <= '0;
            retry_cnt <= '0;
            pll_reset <= 1'b1;
            enclk     <= '0;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_nxt;
            retry_cnt <= retry_nxt;
            pll_reset <= pll_reset_nxt;
            enclk     <= enclk_nxt;
            ready     <= ready_nxt;
            fail      <= fail_nxt;
            if (restart || (state_nxt != state) || release_bit)
                cyc_cnt <= '0;
            else if (state inside {RST_PLL, WAIT_LOCK, STAGE})
                cyc_cnt <= cyc_cnt + CW'(1);
            if (state_nxt != STAGE)
                stage_idx <= '0;
            else if (release_bit)
                stage_idx <= stage_idx + IW'(1);
        end
    end

    // NOTE: each combinational output is given a default before any branch so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        if (restart) begin
            state_nxt = RST_PLL;
            retry_nxt = '0;
        end else begin
            case (state)
                RST_PLL:
                    if (cyc_cnt == RST_LAST) state_nxt = WAIT_LOCK;
                WAIT_LOCK:
                    if (lock_ok) begin
                        state_nxt = STAGE;
                    end else if (cyc_cnt == TO_LAST) begin
                        retry_nxt = retry_cnt + RW'(1);
                        state_nxt = (retry_nxt == RETRY_LIMIT) ? FAIL : RST_PLL;
                    end
                STAGE:
                    if (!lock_ok) begin
                        state_nxt = RST_PLL;
                    end else if (release_bit && (stage_idx == IDX_LAST)) begin
                        state_nxt = RUN;
                        retry_nxt = '0;
                    end
                RUN:
                    if (!lock_ok) state_nxt = RST_PLL;
                FAIL:
                    state_nxt = FAIL;
                default:
                    state_nxt = RST_PLL;
            endcase
        end
    end

    // Output values are derived from the next state so they register together.
    always_comb begin
        pll_reset_nxt = (state_nxt == RST_PLL) || (state_nxt == FAIL);
        ready_nxt     = (state_nxt == RUN);
        fail_nxt      = (state_nxt == FAIL);
        enclk_nxt     = '0;
        if (state_nxt == RUN) begin
            enclk_nxt = en_req;
        end else if ((state_nxt == STAGE) && (state == STAGE)) begin
            for (int i = 0; i < NUM_CLK; i++) begin
                if ((i < int'(stage_idx)) || (release_bit && (i == int'(stage_idx))))
                    enclk_nxt[i] = en_req[i];
            end
        end
    end

`ifdef PLL_SEQ_LOSS_CNT_EN
    logic lock_loss;

    assign lock_loss = ((state == STAGE) || (state == RUN)) && !lock_ok && !restart;

    always_ff @(posedge clkin) begin
        if (reset)
            loss_cnt <= '0;
        else if (lock_loss && (loss_cnt != '1))
            loss_cnt <= loss_cnt + LOSS_CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_pll_enclk_sequencer.sv
// Self-checking bench for pll_enclk_sequencer against a timeline reference model.
// Checks loss_cnt as well when PLL_SEQ_LOSS_CNT_EN is defined.
module tb_pll_enclk_sequencer;

    localparam int NUM_CLK = 2;
    localparam int PRC     = 4;
    localparam int FILT    = 8;
    localparam int GAP     = 3;
    localparam int TO      = 100;
    localparam int MAXR    = 2;
    localparam int RW      = $clog2(MAXR + 1);
    localparam int MAXCYC  = 8000;

    logic               clkin    = 1'b0;
    logic               reset    = 1'b1;
    logic               pll_lock = 1'b0;
    logic               restart  = 1'b0;
    logic [NUM_CLK-1:0] en_req   = '1;
    logic               pll_reset;
    logic [NUM_CLK-1:0] enclk;
    logic               ready;
    logic               fail;
    logic [RW-1:0]      retry_cnt;
`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [15:0]        loss_cnt;
`endif

    pll_enclk_sequencer #(
        .NUM_CLK             (NUM_CLK),
        .PLL_RST_CYCLES      (PRC),
        .LOCK_FILT_CYCLES    (FILT),
        .STAGE_GAP_CYCLES    (GAP),
        .LOCK_TIMEOUT_CYCLES (TO),
        .MAX_RETRIES         (MAXR)
    ) dut (
        .clkin     (clkin),
        .reset     (reset),
        .pll_lock  (pll_lock),
        .en_req    (en_req),
        .restart   (restart),
        .pll_reset (pll_reset),
        .enclk     (enclk),
        .ready     (ready),
        .fail      (fail),
`ifdef PLL_SEQ_LOSS_CNT_EN
        .loss_cnt  (loss_cnt),
`endif
        .retry_cnt (retry_cnt)
    );

    always #5 clkin = ~clkin;

    // Reference model: phases with start timestamps; lock acceptance is read
    // straight from the history of sampled pll_lock values.
    typedef enum {M_PLLRST, M_WAITING, M_STAGING, M_RUNNING, M_FAILED} mphase_t;

    int      cyc;
    bit      samp [0:MAXCYC-1];
    mphase_t m_phase;
    int      m_start, m_clr, m_retry, m_loss;
    logic    m_pll_reset, m_ready, m_fail;
    logic [NUM_CLK-1:0] m_enclk;
    int      vectors, miscompares;

    // Lock accepted during cycle p: the synced lock (pll_lock one edge late)
    // was high for the last FILT cycles, all since the last filter clear.
    function automatic bit m_lock_ok(input int p);
        if (p - FILT + 1 < m_clr) return 1'b0;
        for (int k = p - FILT; k < p; k++)
            if (!samp[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic go(input mphase_t ph);
        m_phase = ph;
        m_start = cyc;
    endtask

    task automatic lost();
        go(M_PLLRST);
        if (m_loss < 65535) m_loss++;
    endtask

    task automatic model_step();
        int p;
        p = cyc - 1;
        samp[cyc] = pll_lock;
        if (reset) begin
            go(M_PLLRST);
            m_retry = 0;
            m_loss  = 0;
        end else if (restart) begin
            go(M_PLLRST);
            m_retry = 0;
        end else begin
            case (m_phase)
                M_PLLRST:
                    if (p - m_start == PRC - 1) begin
                        go(M_WAITING);
                        m_clr = cyc;
                    end
                M_WAITING:
                    if (m_lock_ok(p)) begin
                        go(M_STAGING);
                    end else if (p - m_start == TO - 1) begin
                        m_retry++;
                        go((m_retry == MAXR) ? M_FAILED : M_PLLRST);
                    end
                M_STAGING:
                    if (!m_lock_ok(p)) begin
                        lost();
                    end else if (p - m_start + 1 == NUM_CLK * GAP) begin
                        go(M_RUNNING);
                        m_retry = 0;
                    end
                M_RUNNING:
                    if (!m_lock_ok(p)) lost();
                default: ;
            endcase
        end
        m_pll_reset = (m_phase == M_PLLRST) || (m_phase == M_FAILED);
        m_ready     = (m_phase == M_RUNNING);
        m_fail      = (m_phase == M_FAILED);
        m_enclk     = '0;
        if (m_phase == M_RUNNING) begin
            m_enclk = en_req;
        end else if (m_phase == M_STAGING) begin
            for (int i = 0; i < NUM_CLK; i++)
                if (cyc - m_start >= (i + 1) * GAP) m_enclk[i] = en_req[i];
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkin);
        model_step();
        #1;
        check("pll_reset", 32'(pll_reset), 32'(m_pll_reset));
        check("enclk",     32'(enclk),     32'(m_enclk));
        check("ready",     32'(ready),     32'(m_ready));
        check("fail",      32'(fail),      32'(m_fail));
        check("retry_cnt", 32'(retry_cnt), 32'(m_retry));
`ifdef PLL_SEQ_LOSS_CNT_EN
        check("loss_cnt",  32'(loss_cnt),  32'(m_loss));
`endif
        cyc++;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    initial begin
        int stop_at;
        vectors = 0; miscompares = 0; cyc = 0;
        m_phase = M_PLLRST; m_start = 0; m_clr = 0; m_retry = 0; m_loss = 0;

        // Normal bring-up: reset 3 cycles, lock from cycle 10, all enables requested.
        reset = 1'b1; pll_lock = 1'b0; en_req = 2'b11;
        repeat (3) tick();
        reset = 1'b0;
        while (cyc < 10) tick();
        pll_lock = 1'b1;
        repeat (40) tick();
        repeat (20) begin
            en_req = 2'($urandom);
            tick();
        end

        // One-cycle lock drop in RUN, then full resequence.
        en_req = 2'b11;
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        repeat (40) tick();

        // Masked enables: 2'b10 through STAGE, 2'b01 once running.
        en_req = 2'b10;
        pulse_restart();
        repeat (25) tick();
        en_req = 2'b01;
        repeat (6) tick();

        // Lock chatter shorter than the filter, inside and beyond the timeout.
        for (int span = 70; span <= 170; span += 100) begin
            pll_lock = 1'b0;
            pulse_restart();
            stop_at = cyc + span;
            while (cyc < stop_at) begin
                pll_lock = 1'b1;
                repeat ($urandom_range(FILT - 1, 3)) tick();
                pll_lock = 1'b0;
                repeat ($urandom_range(3, 1)) tick();
            end
            pll_lock = 1'b1;
            repeat (40) begin
                en_req = 2'($urandom);
                tick();
            end
        end

        // Lock never arrives: two timed-out attempts, FAIL held, restart exits.
        pll_lock = 1'b0;
        pulse_restart();
        repeat (2 * (PRC + TO) + 30) tick();
        pulse_restart();
        repeat (12) tick();

        // Restart coinciding with a lock-loss decision in RUN.
        pll_lock = 1'b1;
        repeat (40) tick();
        pll_lock = 1'b0;
        tick();
        tick();
        pulse_restart();
        pll_lock = 1'b1;
        repeat (40) tick();

        // Reset in the middle of staging.
        pulse_restart();
        repeat (14) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (30) begin
            en_req = 2'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
